i2c_master: RTL and testbench

Single-master I2C initiator that runs complete register-addressed byte transactions on the peripheral I2C bus. It is the counterpart of the on-chip I2C responder and speaks its frame format: a write is address, register, data; a read is address with R=1, then one data byte that the master NACKs. The block sits behind the I2C peripheral register interface and drives the pad open-drain controls. It supports SCL clock stretching and reports a NACK status.

---
 rtl/i2c_master.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_master.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// ============================================================================
// i2c_master -- single-master I2C initiator for register-addressed byte
//               transfers, with SCL clock stretching and NACK reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_master (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic [15:0] clk_div_i,
  input  logic        start_i,
  input  logic        read_i,
  input  logic [7:0]  slave_addr_i,
  input  logic [7:0]  reg_addr_i,
  input  logic [7:0]  wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        nack_o,
  output logic [7:0]  rdata_o,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_o,
  output logic        sda_o,
  output logic        scl_oe_o,
  output logic        sda_oe_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_REG   = 3'd3;
  localparam logic [2:0] ST_WDATA = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  quarter_q, quarter_d;
  logic [3:0]  bit_q, bit_d;
  logic        first_q, first_d;
  logic [7:0]  addr_byte_q, addr_byte_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        nack_q, nack_d;
  logic        done_q, done_d;
  logic        sda_oe_q, sda_oe_d;

  logic        in_byte;
  logic        stall;
  logic        tick;
  logic        last_quarter;
  logic        byte_end;
  logic        accept;
  logic        sample;
  logic [7:0]  cur_byte;
  logic [2:0]  bit_idx;
  logic        sda_target;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = slave_addr_i[0];

  assign in_byte = (state_q == ST_ADDR) || (state_q == ST_REG) ||
                   (state_q == ST_WDATA) || (state_q == ST_RDATA);

  // The quarter count freezes while a released SCL is still held low by the bus.
  assign stall = (((in_byte && (quarter_q == 2'd2)) ||
                   ((state_q == ST_STOP) && (quarter_q == 2'd1))) && !scl_i);

  assign tick = (cnt_q == 16'd0) && !stall;

  assign last_quarter = in_byte                ? (quarter_q == 2'd3) :
                        (state_q == ST_START)  ? (quarter_q == 2'd1) :
                                                 (quarter_q == 2'd2);

  assign byte_end = in_byte && tick && (quarter_q == 2'd3) && (bit_q == 4'd8);
  assign accept   = (state_q == ST_IDLE) && enable_i && start_i;
  assign sample   = in_byte && (quarter_q == 2'd3) && first_q;
  assign bit_idx  = 3'd7 - bit_q[2:0];

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      quarter_q   <= '0;
      bit_q       <= '0;
      first_q     <= 1'b0;
      addr_byte_q <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      shift_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      nack_q      <= 1'b0;
      done_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      first_q     <= first_d;
      addr_byte_q <= addr_byte_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      done_q      <= done_d;
      sda_oe_q    <= sda_oe_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i) state_d = ST_START;
        ST_START: if (tick && (quarter_q == 2'd1)) state_d = ST_ADDR;
        ST_ADDR:  if (byte_end) state_d = ack_q ? ST_STOP :
                                          (addr_byte_q[0] ? ST_RDATA : ST_REG);
        ST_REG:   if (byte_end) state_d = ack_q ? ST_STOP : ST_WDATA;
        ST_WDATA: if (byte_end) state_d = ST_STOP;
        ST_RDATA: if (byte_end) state_d = ST_STOP;
        ST_STOP:  if (tick && (quarter_q == 2'd2)) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Timebase, bit counter, shift registers and status
  always_comb begin
    cnt_d       = cnt_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    first_d     = 1'b0;
    addr_byte_d = addr_byte_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;
    nack_d      = nack_q;
    done_d      = 1'b0;

    if (!enable_i) begin
      cnt_d     = '0;
      quarter_d = '0;
      bit_d     = '0;
    end else if (accept) begin
      cnt_d       = clk_div_i;
      quarter_d   = '0;
      bit_d       = '0;
      first_d     = 1'b1;
      addr_byte_d = {slave_addr_i[7:1], read_i};
      reg_d       = reg_addr_i;
      wdata_d     = wdata_i;
      nack_d      = 1'b0;
    end else if (state_q != ST_IDLE) begin
      if (!stall) begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          cnt_d   = clk_div_i;
          first_d = 1'b1;
          if (last_quarter) begin
            quarter_d = '0;
            bit_d     = (in_byte && (bit_q != 4'd8)) ? bit_q + 4'd1 : 4'd0;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end
      if (sample) begin
        if (bit_q == 4'd8) ack_d = sda_i;
        else               shift_d = {shift_q[6:0], sda_i};
      end
      if (byte_end && (state_q != ST_RDATA) && ack_q) nack_d = 1'b1;
      if (byte_end && (state_q == ST_RDATA)) rdata_d = shift_q;
      if ((state_q == ST_STOP) && tick && (quarter_q == 2'd2)) done_d = 1'b1;
    end
  end

  // Bus drive; SDA follows its target one cycle late so it moves only after SCL has fallen
  always_comb begin
    scl_oe_o   = 1'b0;
    sda_target = 1'b0;
    case (state_q)
      ST_ADDR:  cur_byte = addr_byte_q;
      ST_REG:   cur_byte = reg_q;
      default:  cur_byte = wdata_q;
    endcase
    case (state_q)
      ST_START: sda_target = (quarter_q == 2'd1);
      ST_ADDR, ST_REG, ST_WDATA, ST_RDATA: begin
        scl_oe_o   = (quarter_q < 2'd2);
        sda_target = (state_q != ST_RDATA) && (bit_q != 4'd8) && !cur_byte[bit_idx];
      end
      ST_STOP: begin
        scl_oe_o   = (quarter_q == 2'd0);
        sda_target = (quarter_q != 2'd2);
      end
      default: ;
    endcase
    sda_oe_d = enable_i && sda_target;
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign nack_o   = nack_q;
  assign rdata_o  = rdata_q;
  assign sda_oe_o = sda_oe_q;
  assign scl_o    = 1'b0;
  assign sda_o    = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master.sv
// Testbench for i2c_master: behavioural responder on the bus plus a transaction-level model.
`default_nettype none

module tb_i2c_master;

  localparam logic [6:0] RESP_ADDR = 7'h50;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        enable_i;
  logic [15:0] clk_div_i;
  logic        start_i;
  logic        read_i;
  logic [7:0]  slave_addr_i;
  logic [7:0]  reg_addr_i;
  logic [7:0]  wdata_i;
  logic        busy_o, done_o, nack_o;
  logic [7:0]  rdata_o;
  logic        scl_o, sda_o, scl_oe_o, sda_oe_o;
  logic        scl_line, sda_line;

  logic        resp_sda_low;
  logic        stretch_hold;
  logic        stretch_req = 1'b0;
  int          stretch_len = 0;
  int          stretch_cnt;

  logic [7:0]  resp_data = 8'h00;
  logic        prev_scl, prev_sda, rs_active, rs_rw, master_ack;
  int          rs_bit, rs_byte;
  logic [7:0]  rs_shift, got_reg, got_data;
  int          start_cnt = 0, stop_cnt = 0, wr_cnt = 0;

  int          passed = 0, failed = 0, total = 0;
  logic [7:0]  model_rdata = 8'h00;
  logic        model_nack = 1'b0;

  assign scl_line = ~scl_oe_o & ~stretch_hold;
  assign sda_line = ~sda_oe_o & ~resp_sda_low;

  i2c_master dut (
    .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .clk_div_i(clk_div_i),
    .start_i(start_i), .read_i(read_i), .slave_addr_i(slave_addr_i),
    .reg_addr_i(reg_addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .nack_o(nack_o), .rdata_o(rdata_o), .scl_i(scl_line), .sda_i(sda_line),
    .scl_o(scl_o), .sda_o(sda_o), .scl_oe_o(scl_oe_o), .sda_oe_o(sda_oe_o)
  );

  always #5 clk = ~clk;

  // Responder at RESP_ADDR: ACKs write bytes, returns resp_data on reads
  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_scl <= 1'b1; prev_sda <= 1'b1; rs_active <= 1'b0; rs_rw <= 1'b0;
      rs_bit <= -1; rs_byte <= 0; rs_shift <= '0; resp_sda_low <= 1'b0;
    end else begin
      prev_scl <= scl_line;
      prev_sda <= sda_line;
      if (prev_scl && scl_line && prev_sda && !sda_line) begin
        start_cnt <= start_cnt + 1;
        rs_active <= 1'b1; rs_rw <= 1'b0; rs_bit <= -1; rs_byte <= 0;
        resp_sda_low <= 1'b0; master_ack <= 1'b0;
      end else if (prev_scl && scl_line && !prev_sda && sda_line) begin
        stop_cnt <= stop_cnt + 1;
        rs_active <= 1'b0; resp_sda_low <= 1'b0;
      end else if (rs_active && !prev_scl && scl_line) begin
        if (rs_bit >= 0 && rs_bit < 8 && !(rs_byte > 0 && rs_rw))
          rs_shift <= {rs_shift[6:0], sda_line};
        if (rs_bit == 8 && rs_byte > 0 && rs_rw) master_ack <= sda_line;
      end else if (rs_active && prev_scl && !scl_line) begin
        rs_bit  <= (rs_bit == 8) ? 0 : rs_bit + 1;
        rs_byte <= (rs_bit == 8) ? rs_byte + 1 : rs_byte;
        if (rs_bit == 7) begin
          if (rs_byte == 0) begin
            if (rs_shift[7:1] == RESP_ADDR) begin
              rs_rw <= rs_shift[0]; resp_sda_low <= 1'b1;
            end else begin
              rs_active <= 1'b0; resp_sda_low <= 1'b0;
            end
          end else if (!rs_rw && rs_byte == 1) begin
            got_reg <= rs_shift; resp_sda_low <= 1'b1;
          end else if (!rs_rw && rs_byte == 2) begin
            got_data <= rs_shift; wr_cnt <= wr_cnt + 1; resp_sda_low <= 1'b1;
          end else begin
            resp_sda_low <= 1'b0;
          end
        end else if (rs_rw && rs_bit == 8 && rs_byte == 0) begin
          resp_sda_low <= ~resp_data[7];
        end else if (rs_rw && rs_byte == 1 && rs_bit >= 0 && rs_bit <= 6) begin
          resp_sda_low <= ~resp_data[6 - rs_bit];
        end else begin
          resp_sda_low <= 1'b0;
        end
      end
    end
  end

  // Holds SCL low for stretch_len cycles beyond the master's release in ADDR bit 3
  always @(negedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      stretch_hold <= 1'b0; stretch_cnt <= 0;
    end else if (!stretch_req) begin
      stretch_hold <= 1'b0; stretch_cnt <= 0;
    end else if (!stretch_hold && stretch_cnt == 0 && rs_active &&
                 rs_byte == 0 && rs_bit == 3 && !scl_line) begin
      stretch_hold <= 1'b1;
    end else if (stretch_hold && !scl_oe_o) begin
      if (stretch_cnt == stretch_len) stretch_hold <= 1'b0;
      else stretch_cnt <= stretch_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input int div, input logic rd, input logic [7:0] sa,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input int stretch, input logic scramble);
    int cyc, s0, p0, w0, nbytes, exp_lat;
    logic hit;
    clk_div_i = div[15:0]; read_i = rd; slave_addr_i = sa;
    reg_addr_i = ra; wdata_i = wd;
    stretch_len = stretch; stretch_req = (stretch > 0);
    s0 = start_cnt; p0 = stop_cnt; w0 = wr_cnt;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_at_accept", busy_o, 1);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < 3000) begin
      if (scramble && cyc == 17) begin
        start_i = 1'b1; read_i = ~rd; slave_addr_i = 8'($urandom);
        reg_addr_i = 8'($urandom); wdata_i = 8'($urandom);
      end
      if (cyc == 18) start_i = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    // Transaction-level expectation: frame length in quarters from the byte count
    hit     = (sa[7:1] == RESP_ADDR);
    nbytes  = !hit ? 1 : (rd ? 2 : 3);
    exp_lat = (2 + 36 * nbytes + 3) * (div + 1) + stretch;
    if (hit && rd) model_rdata = resp_data;
    model_nack = !hit;
    check("latency", cyc, exp_lat);
    check("busy_low_at_done", busy_o, 0);
    check("nack", nack_o, model_nack);
    check("rdata", rdata_o, model_rdata);
    check("start_count", start_cnt - s0, 1);
    check("stop_count", stop_cnt - p0, 1);
    if (hit && !rd) begin
      check("wr_count", wr_cnt - w0, 1);
      check("resp_reg", got_reg, ra);
      check("resp_data", got_data, wd);
    end else begin
      check("no_write", wr_cnt - w0, 0);
    end
    if (hit && rd) check("master_nacks_read", master_ack, 1);
    @(posedge clk); #1;
    check("done_one_cycle", done_o, 0);
    stretch_req = 1'b0;
  endtask

  initial begin
    int cyc, dones, busies;
    rst_ni = 1'b0; enable_i = 1'b1; clk_div_i = 16'd4; start_i = 1'b0;
    read_i = 1'b0; slave_addr_i = 8'h00; reg_addr_i = 8'h00; wdata_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_nack", nack_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_scl_oe", scl_oe_o, 0);
    check("rst_sda_oe", sda_oe_o, 0);
    check("scl_o_zero", scl_o, 0);
    check("sda_o_zero", sda_o, 0);
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Directed cases
    run_txn(4, 1'b0, 8'hA0, 8'h12, 8'hA5, 0, 1'b0);
    resp_data = 8'h3C;
    run_txn(4, 1'b1, 8'hA1, 8'h00, 8'h00, 0, 1'b0);
    run_txn(4, 1'b0, 8'h42, 8'h12, 8'hA5, 0, 1'b0);
    run_txn(4, 1'b0, 8'hA0, 8'h12, 8'hA5, 50, 1'b0);

    // Randomized transactions with post-accept input scrambling
    for (int i = 0; i < 8; i++) begin
      int div;
      logic rd;
      logic [7:0] sa;
      div = $urandom_range(3, 7);
      rd  = 1'($urandom_range(0, 1));
      sa  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) sa[7:1] = RESP_ADDR;
      else if (sa[7:1] == RESP_ADDR) sa[7:1] = 7'h51;
      resp_data = 8'($urandom);
      run_txn(div, rd, sa, 8'($urandom), 8'($urandom), 0, 1'b1);
    end

    // Disable during REG bit 4
    clk_div_i = 16'd4; read_i = 1'b0; slave_addr_i = 8'hA0;
    reg_addr_i = 8'h34; wdata_i = 8'h56;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!(rs_byte == 1 && rs_bit == 4) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_reg_bit4", cyc < 2000, 1);
    enable_i = 1'b0;
    @(posedge clk); #1;
    check("dis_scl_oe", scl_oe_o, 0);
    check("dis_sda_oe", sda_oe_o, 0);
    check("dis_busy", busy_o, 0);
    check("dis_done", done_o, 0);
    check("dis_nack_hold", nack_o, model_nack);
    check("dis_rdata_hold", rdata_o, model_rdata);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    dones = 0; busies = 0;
    repeat (20) begin
      if (done_o) dones++;
      if (busy_o) busies++;
      @(posedge clk); #1;
    end
    check("dis_no_done", dones, 0);
    check("dis_start_ignored", busies, 0);
    enable_i = 1'b1;
    @(posedge clk); #1;
    run_txn(4, 1'b0, 8'hA0, 8'h77, 8'h88, 0, 1'b0);

    // Reset in the middle of RDATA
    resp_data = 8'h96;
    run_txn(5, 1'b1, 8'hA0, 8'h00, 8'h00, 0, 1'b0);
    resp_data = 8'h3C;
    read_i = 1'b1; slave_addr_i = 8'hA0; clk_div_i = 16'd4;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 0;
    while (!(rs_byte == 1 && rs_bit == 3) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_rdata_bit3", cyc < 2000, 1);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_ignores_start", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_nack", nack_o, 0);
    check("arst_rdata", rdata_o, 0);
    check("arst_scl_oe", scl_oe_o, 0);
    check("arst_sda_oe", sda_oe_o, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    busies = 0;
    repeat (300) begin
      if (busy_o) busies++;
      @(posedge clk); #1;
    end
    check("no_second_txn", busies, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
